// File: rtl/dl_pkg.sv
// Shared definitions for the delay-line sweep controller.
//   sweep_state_t : sequencer states
//   c_frame_hdr   : first byte of every result frame
//   c_frame_len   : number of bytes in a result frame
//   c_cmd_n_msb   : top bit of the burst exponent field in the command byte
package dl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_GAP,
        S_REPORT
    } sweep_state_t;

    localparam logic [7:0] c_frame_hdr = 8'hA5;
    localparam int         c_frame_len = 8;
    localparam int         c_cmd_n_msb = 3;

endpackage

// File: rtl/dl_sweep_stats.sv
// Capture statistics accumulator: running min / max / sum of hit taps and a
// saturating miss count, plus the burst mean (sum >> N).
//   i_clk, i_nrst : clock, async active-low reset
//   i_init        : clear statistics for a new burst
//   i_rec         : record one sample this cycle
//   i_hit, i_tap  : sample qualifier and tap index (miss when i_hit=0)
//   i_n           : burst exponent used for the mean shift
//   o_min, o_max  : tap extremes, zero-extended to 16 bits
//   o_mean        : truncated mean, misses counted as zero
//   o_miss        : miss count, saturating at 255
module dl_sweep_stats
    import dl_pkg::*;
#(
    parameter int p_tap_width = 12,
    parameter int p_max_log2  = 8
) (
    input  logic                   i_clk,
    input  logic                   i_nrst,
    input  logic                   i_init,
    input  logic                   i_rec,
    input  logic                   i_hit,
    input  logic [p_tap_width-1:0] i_tap,
    input  logic [3:0]             i_n,
    output logic [15:0]            o_min,
    output logic [15:0]            o_max,
    output logic [15:0]            o_mean,
    output logic [7:0]             o_miss
);

    // Wide enough for 2^p_max_log2 full-scale taps, so no overflow check.
    localparam int c_sum_w = p_tap_width + p_max_log2;

    logic [15:0]        r_min;
    logic [15:0]        r_max;
    logic [c_sum_w-1:0] r_sum;
    logic [7:0]         r_miss;
    logic [15:0]        w_tap16;

    assign w_tap16 = 16'(i_tap);

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_min  <= 16'hFFFF;
            r_max  <= 16'h0000;
            r_sum  <= '0;
            r_miss <= 8'h00;
        end else if (i_init) begin
            r_min  <= 16'hFFFF;
            r_max  <= 16'h0000;
            r_sum  <= '0;
            r_miss <= 8'h00;
        end else if (i_rec) begin
            if (i_hit) begin
                if (w_tap16 < r_min) r_min <= w_tap16;
                if (w_tap16 > r_max) r_max <= w_tap16;
                r_sum <= r_sum + c_sum_w'(i_tap);
            end else if (r_miss != 8'hFF) begin
                r_miss <= r_miss + 8'd1;
            end
        end
    end

    assign o_min  = r_min;
    assign o_max  = r_max;
    // sum >> N never exceeds the largest tap, so 16 bits always hold it.
    assign o_mean = 16'(r_sum >> i_n);
    assign o_miss = r_miss;

endmodule

// File: rtl/dl_sweep_ctrl.sv
// Delay-line sweep sequencer. A command byte starts a burst of 2^N
// launch/capture cycles; each capture (or timeout) is folded into the stats
// block, then an 8-byte result frame is streamed out on the TX byte interface.
//   i_clk, i_nrst          : clock, async active-low reset
//   i_cmd_valid/i_cmd_data : command strobe and byte, [3:0] = requested N
//   o_busy                 : high whenever the sequencer is not idle
//   o_cap_start            : one-cycle launch pulse
//   i_cap_done/hit/tap     : capture result from the delay-line datapath
//   o_tx_valid/o_tx_data   : result byte stream
//   i_tx_ready             : byte accepted when valid & ready
module dl_sweep_ctrl
    import dl_pkg::*;
#(
    parameter int p_tap_width = 12,
    parameter int p_max_log2  = 8,
    parameter int p_timeout   = 8192,
    parameter int p_gap       = 16
) (
    input  logic                   i_clk,
    input  logic                   i_nrst,
    input  logic                   i_cmd_valid,
    input  logic [7:0]             i_cmd_data,
    output logic                   o_busy,
    output logic                   o_cap_start,
    input  logic                   i_cap_done,
    input  logic                   i_cap_hit,
    input  logic [p_tap_width-1:0] i_cap_tap,
    output logic                   o_tx_valid,
    output logic [7:0]             o_tx_data,
    input  logic                   i_tx_ready
);

    // One counter serves both the WAIT timeout and the GAP length.
    localparam int c_tw = $clog2((p_timeout > p_gap ? p_timeout : p_gap) + 1) + 1;
    localparam logic [c_tw-1:0] c_tmo_last = c_tw'(p_timeout - 1);
    localparam logic [c_tw-1:0] c_gap_last = c_tw'(p_gap - 1);
    localparam int c_cw = p_max_log2 + 1;

    sweep_state_t    r_state;
    sweep_state_t    w_next;
    logic [c_tw-1:0] r_tmo;
    logic [c_cw-1:0] r_cnt;
    logic [c_cw-1:0] w_last_idx;
    logic [3:0]      r_n;
    logic [3:0]      w_cmd_n;
    logic [2:0]      r_byte;
    logic            w_accept;
    logic            w_tmo_hit;
    logic            w_rec;
    logic            w_rec_hit;
    logic            w_last;
    logic [15:0]     w_min;
    logic [15:0]     w_max;
    logic [15:0]     w_mean;
    logic [7:0]      w_miss;
    logic [7-c_cmd_n_msb-1:0] w_unused_cmd;

    assign w_unused_cmd = i_cmd_data[7:c_cmd_n_msb+1];

    assign w_cmd_n = (int'(i_cmd_data[c_cmd_n_msb:0]) > p_max_log2) ?
                     4'(p_max_log2) : 4'(i_cmd_data[c_cmd_n_msb:0]);

    assign w_accept   = (r_state == S_IDLE) && i_cmd_valid;
    assign w_tmo_hit  = (r_tmo == c_tmo_last);
    // A done in the timeout cycle still counts as a real capture.
    assign w_rec      = (r_state == S_WAIT) && (i_cap_done || w_tmo_hit);
    assign w_rec_hit  = i_cap_done && i_cap_hit;
    assign w_last_idx = (c_cw'(1) << r_n) - c_cw'(1);
    assign w_last     = (r_cnt == w_last_idx);

    // State register
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (i_cmd_valid) w_next = S_LAUNCH;
            S_LAUNCH: w_next = S_WAIT;
            S_WAIT: begin
                if (w_rec) begin
                    if (w_last)          w_next = S_REPORT;
                    else if (p_gap == 0) w_next = S_LAUNCH;
                    else                 w_next = S_GAP;
                end
            end
            S_GAP:    if (r_tmo == c_gap_last) w_next = S_LAUNCH;
            S_REPORT: if (i_tx_ready && (r_byte == 3'(c_frame_len - 1))) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Outputs. Frame bytes are a pure mux of the byte index and the frozen
    // stats, so the data holds steady while the receiver stalls.
    always_comb begin
        o_busy      = (r_state != S_IDLE);
        o_cap_start = (r_state == S_LAUNCH);
        o_tx_valid  = (r_state == S_REPORT);
        o_tx_data   = 8'h00;
        if (r_state == S_REPORT) begin
            case (r_byte)
                3'd0:    o_tx_data = c_frame_hdr;
                3'd1:    o_tx_data = w_min[15:8];
                3'd2:    o_tx_data = w_min[7:0];
                3'd3:    o_tx_data = w_max[15:8];
                3'd4:    o_tx_data = w_max[7:0];
                3'd5:    o_tx_data = w_mean[15:8];
                3'd6:    o_tx_data = w_mean[7:0];
                default: o_tx_data = w_miss;
            endcase
        end
    end

    // Counters: timeout/gap restarts on every state change; sample count and
    // burst exponent are latched on command accept.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_tmo  <= '0;
            r_cnt  <= '0;
            r_n    <= 4'd0;
            r_byte <= 3'd0;
        end else begin
            if ((r_state == S_WAIT || r_state == S_GAP) && (w_next == r_state))
                r_tmo <= r_tmo + c_tw'(1);
            else
                r_tmo <= '0;

            if (w_accept) begin
                r_n   <= w_cmd_n;
                r_cnt <= '0;
            end else if (w_rec) begin
                r_cnt <= r_cnt + c_cw'(1);
            end

            if (r_state != S_REPORT) r_byte <= 3'd0;
            else if (i_tx_ready)     r_byte <= r_byte + 3'd1;
        end
    end

    dl_sweep_stats #(
        .p_tap_width (p_tap_width),
        .p_max_log2  (p_max_log2)
    ) u_stats (
        .i_clk  (i_clk),
        .i_nrst (i_nrst),
        .i_init (w_accept),
        .i_rec  (w_rec),
        .i_hit  (w_rec_hit),
        .i_tap  (i_cap_tap),
        .i_n    (r_n),
        .o_min  (w_min),
        .o_max  (w_max),
        .o_mean (w_mean),
        .o_miss (w_miss)
    );

endmodule
